// File: rtl/hack_cpu_mc_if.sv
// hack_cpu_mc_if: data-memory req/ack bus between the Hack core and the RAM/MMIO fabric
interface hack_cpu_mc_if #(
  parameter int DW = 16,
  parameter int AW = 15
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] addressM;
  logic [DW-1:0] outM;
  logic [DW-1:0] inM;
  logic          mem_ack;
  modport master (output mem_req, output mem_we, output addressM, output outM, input inM, input mem_ack);
  modport slave  (input mem_req, input mem_we, input addressM, input outM, output inM, output mem_ack);
endinterface

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU core with req/ack data memory and performance counters
module hack_cpu_mc #(
  parameter int DW    = 16,
  parameter int AW    = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instruction,
  output logic [AW-1:0]    addressI,
  hack_cpu_mc_if.master    mem,
  output logic             retire,
  output logic             illegal,
  output logic [DW-1:0]    A,
  output logic [DW-1:0]    D,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);
  typedef enum logic [1:0] {EXEC, RD_WAIT, EXE_M, WR_WAIT} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [DW-1:0]    a_q, a_d, d_q, d_d, mreg_q, mreg_d, outm_q, outm_d;
  logic             req_q, req_d, we_q, we_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic             is_a, is_c, jump, commit, drop;
  logic [DW-1:0]    x0, x1, y0, y1, f0, alu;
  assign is_a = ~instruction[15];
  assign is_c = &instruction[15:13];
  // ALU on x = D and y = A or latched M, plus the jump condition on its signed result
  always_comb begin
    x0   = instruction[11] ? '0 : d_q;
    x1   = instruction[10] ? ~x0 : x0;
    y0   = instruction[9] ? '0 : (instruction[12] ? mreg_q : a_q);
    y1   = instruction[8] ? ~y0 : y0;
    f0   = instruction[7] ? x1 + y1 : x1 & y1;
    alu  = instruction[6] ? ~f0 : f0;
    jump = is_c & ((instruction[2] & alu[DW-1]) | (instruction[1] & ~|alu) |
                   (instruction[0] & ~alu[DW-1] & |alu));
  end
  // Sequencer: memory handshakes, then a single commit of A, D and PC together
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    mreg_d  = mreg_q;
    outm_d  = outm_q;
    req_d   = req_q;
    we_d    = we_q;
    commit  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      EXEC: begin
        if (is_a) begin
          commit = 1'b1;
        end else if (!is_c) begin
          drop = 1'b1;
        end else if (instruction[12]) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = RD_WAIT;
        end else if (instruction[3]) begin
          outm_d  = alu;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WR_WAIT;
        end else begin
          commit = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem.mem_ack) begin
          mreg_d  = mem.inM;
          req_d   = 1'b0;
          state_d = EXE_M;
        end
      end
      EXE_M: begin
        if (instruction[3]) begin
          outm_d  = alu;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = WR_WAIT;
        end else begin
          commit  = 1'b1;
          state_d = EXEC;
        end
      end
      WR_WAIT: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          commit  = 1'b1;
          state_d = EXEC;
        end
      end
    endcase
    if (commit) begin
      a_d  = is_a ? DW'(instruction[14:0]) : (instruction[5] ? alu : a_q);
      d_d  = (is_c & instruction[4]) ? alu : d_q;
      pc_d = jump ? a_q[AW-1:0] : pc_q + 1'b1;
    end
    if (drop) pc_d = pc_q + 1'b1;
    cyc_d = cyc_q + 1'b1;
    ret_d = ret_q + CNT_W'(commit);
  end
  // State register; reset abandons any in-flight access immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EXEC;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      mreg_q  <= '0;
      outm_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      mreg_q  <= mreg_d;
      outm_q  <= outm_d;
      req_q   <= req_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
    end
  end
  assign addressI     = pc_q;
  assign A            = a_q;
  assign D            = d_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_we   = we_q;
  assign mem.addressM = a_q[AW-1:0];
  assign mem.outM     = outm_q;
  assign retire       = commit & reset;
  assign illegal      = drop & reset;
  assign cycle_cnt    = cyc_q;
  assign retired_cnt  = ret_q;
endmodule
